regfile_wb_ctrl: RTL

- Write-side controller for the 32x32 register file (r0 hardwired to zero).
- Merges single-cycle ALU writebacks with out-of-order long-latency results (mul/div, loads) onto the register file's single write port (wn/d/we).
- Long-latency results queue in a small FIFO.
- A busy scoreboard lets the issue stage stall on RAW hazards against registers with pending long-latency writes.

---
 rtl/wb_pkg.sv | 12 +
 rtl/regfile_wb_ctrl_if.sv | 37 +++
 rtl/wb_fifo.sv | 48 ++++
 rtl/regfile_wb_ctrl.sv | 86 ++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file writeback controller.
// An entry is one pending register write: destination index plus data.
package wb_pkg;
   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [AW-1:0] wn;
      logic [DW-1:0] d;
   } wb_entry_t;
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Bundle of the ALU writeback, long-latency result and register-file write-port signals.
// The master side is the pipeline/testbench; the slave side is the controller.
interface regfile_wb_ctrl_if
   import wb_pkg::*;
#(
   parameter int AW    = wb_pkg::AW,
   parameter int DW    = wb_pkg::DW,
   parameter int DEPTH = wb_pkg::DEPTH
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                 alu_valid;
   logic [AW-1:0]        alu_wn;
   logic [DW-1:0]        alu_d;
   logic                 alu_hold;
   logic                 ll_issue;
   logic [AW-1:0]        ll_issue_wn;
   logic                 ll_valid;
   logic [AW-1:0]        ll_wn;
   logic [DW-1:0]        ll_d;
   logic                 ll_ready;
   logic [AW-1:0]        wn;
   logic [DW-1:0]        d;
   logic                 we;
   logic [(1<<AW)-1:0]   busy;
   logic [CW-1:0]        ll_count;

   modport master (
      output alu_valid, alu_wn, alu_d, ll_issue, ll_issue_wn, ll_valid, ll_wn, ll_d,
      input  alu_hold, ll_ready, wn, d, we, busy, ll_count
   );

   modport slave (
      input  alu_valid, alu_wn, alu_d, ll_issue, ll_issue_wn, ll_valid, ll_wn, ll_d,
      output alu_hold, ll_ready, wn, d, we, busy, ll_count
   );
endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of pending long-latency register writes.
// Pointers wrap naturally because DEPTH is a power of two.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = wb_pkg::DEPTH,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic           clk,
   input  logic           clrn,
   input  logic           push,
   input  wb_entry_t      push_data,
   input  logic           pop,
   output wb_entry_t      head,
   output logic           full,
   output logic           empty,
   output logic [CW-1:0]  count
);
   wb_entry_t     mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   // Storage needs no reset; only the pointers and occupancy define what is valid.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Merges ALU writebacks and queued long-latency results onto the single register-file
// write port, and tracks which registers still have a long-latency write pending.
module regfile_wb_ctrl
   import wb_pkg::*;
#(
   parameter int DEPTH = wb_pkg::DEPTH,
   parameter int AW    = wb_pkg::AW,
   parameter int DW    = wb_pkg::DW
) (
   input logic              clk,
   input logic              clrn,
   regfile_wb_ctrl_if.slave bus
);
   localparam int NR = 1 << AW;
   localparam int CW = $clog2(DEPTH) + 1;

   wb_entry_t     head;
   wb_entry_t     push_data;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          alu_req;
   logic [CW-1:0] count;
   logic [NR-1:0] busy_q;
   logic [NR-1:0] busy_next;

   assign alu_req      = bus.alu_valid && (bus.alu_wn != '0);
   assign bus.ll_ready = clrn && !full;
   assign push         = bus.ll_valid && bus.ll_ready;
   assign push_data    = '{wn: bus.ll_wn, d: bus.ll_d};
   assign bus.ll_count = count;
   assign bus.busy     = busy_q;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .clrn      (clrn),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   // A full FIFO outranks the ALU so long-latency producers can never deadlock.
   always_comb begin
      bus.we       = 1'b0;
      bus.wn       = '0;
      bus.d        = '0;
      bus.alu_hold = 1'b0;
      pop          = 1'b0;
      if (clrn) begin
         if (full && alu_req) begin
            pop          = 1'b1;
            bus.alu_hold = 1'b1;
            bus.we       = (head.wn != '0);
            bus.wn       = head.wn;
            bus.d        = head.d;
         end else if (alu_req) begin
            bus.we = 1'b1;
            bus.wn = bus.alu_wn;
            bus.d  = bus.alu_d;
         end else if (!empty) begin
            pop    = 1'b1;
            bus.we = (head.wn != '0);
            bus.wn = head.wn;
            bus.d  = head.d;
         end
      end
   end

   // Issue sets after the pop clears, so a same-register collision leaves it busy.
   always_comb begin
      busy_next = busy_q;
      if (pop) busy_next[head.wn] = 1'b0;
      if (bus.ll_issue && (bus.ll_issue_wn != '0)) busy_next[bus.ll_issue_wn] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) busy_q <= '0;
      else       busy_q <= busy_next;
   end
endmodule
